// File: rtl/fifo_param_pkg.sv
// Shared definitions for the parametrised router FIFO.
// Latency: n/a (types, default sizes and the accept/error decode helper only).
// Backpressure: n/a.
//
// Default geometry matches the original router FIFO: 10-bit words, 8 entries.
// The top DEST_W bits of every word are the destination field and the rest is payload.
// The FIFO itself never looks inside the word.
package fifo_param_pkg;

  localparam int WORD_SIZE_DEF = 10;
  localparam int DEPTH_DEF     = 8;
  localparam int PTR_DEF       = 3;

  // Destination field occupies [WORD_SIZE-1 -: DEST_W]
  localparam int DEST_W        = 2;

  // Per-cycle operation decode: what the FIFO actually does this edge
  typedef struct packed {
    logic push;  // write accepted
    logic pop;   // read accepted
    logic err;   // overflow or underflow attempt seen
  } fifo_op_t;

  // Accept rules are evaluated on pre-edge flags. A read while full frees the
  // slot, so a concurrent write is still accepted. A read while empty is always
  // rejected, even when a write arrives in the same cycle, because there is no bypass.
  function automatic fifo_op_t fifo_decode(input logic wr,
                                           input logic rd,
                                           input logic full,
                                           input logic empty);
    fifo_op_t op;
    op.pop  = rd & ~empty;
    op.push = wr & (~full | rd);
    op.err  = (wr & full & ~rd) | (rd & empty);
    return op;
  endfunction

endpackage

// File: rtl/fifo_param_mem.sv
// Storage array for fifo_param: DEPTH x WORD_SIZE, one write port, one async read port.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none here; the caller gates wr_en.
//
// Ports: clk, wr_en/wr_addr/wr_dat (synchronous write), rd_addr -> rd_dat (asynchronous read).
// The array has no reset and may hold stale contents after a FIFO reset.
module fifo_param_mem #(
  parameter int WORD_SIZE = 10,
  parameter int DEPTH     = 8,
  parameter int PTR       = 3
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [PTR-1:0]       wr_addr,
  input  logic [WORD_SIZE-1:0] wr_dat,
  input  logic [PTR-1:0]       rd_addr,
  output logic [WORD_SIZE-1:0] rd_dat
);

  logic [WORD_SIZE-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO between the router input stage and the output arbiters.
// Latency: registered read, with data_out/valid_out 1 cycle after an accepted read (FIFO_FWFT_EN: 0-cycle fall-through).
// Backpressure: a write while full is dropped unless a read frees a slot, and a read while empty is dropped; either sets sticky error.
//
// Ports:
//   clk, reset (sync, active-high)
//   fifo_wr / fifo_data_in                write side
//   fifo_rd -> fifo_data_out, fifo_valid_out   read side
//   full_threshold, empty_threshold       live almost_full / almost_empty levels
//   fifo_count, fifo_full, fifo_empty, almost_full, almost_empty, error   status
// Build option: define FIFO_FWFT_EN for first-word fall-through output.
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int PTR       = PTR_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_wr,
  input  logic                 fifo_rd,
  input  logic [PTR:0]         full_threshold,
  input  logic [PTR:0]         empty_threshold,
  input  logic [WORD_SIZE-1:0] fifo_data_in,
  output logic [WORD_SIZE-1:0] fifo_data_out,
  output logic                 fifo_valid_out,
  output logic [PTR:0]         fifo_count,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 error
);

  localparam logic [PTR:0]   DEPTH_CNT = (PTR+1)'(DEPTH);
  localparam logic [PTR-1:0] PTR_ONE   = PTR'(1);
  localparam logic [PTR:0]   CNT_ONE   = (PTR+1)'(1);

  logic [PTR-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR:0]         count_q,  count_d;
  logic                 error_q,  error_d;
  logic [WORD_SIZE-1:0] rd_dat;
  fifo_op_t             op;

  // Flags decode the count register only, so they never glitch on request inputs
  assign fifo_full    = (count_q == DEPTH_CNT);
  assign fifo_empty   = (count_q == '0);
  assign almost_full  = (count_q >= full_threshold);
  assign almost_empty = (count_q <= empty_threshold);
  assign fifo_count   = count_q;
  assign error        = error_q;

  assign op = fifo_decode(fifo_wr, fifo_rd, fifo_full, fifo_empty);

  fifo_param_mem #(
    .WORD_SIZE (WORD_SIZE),
    .DEPTH     (DEPTH),
    .PTR       (PTR)
  ) u_mem (
    .clk     (clk),
    .wr_en   (op.push),
    .wr_addr (wr_ptr_q),
    .wr_dat  (fifo_data_in),
    .rd_addr (rd_ptr_q),
    .rd_dat  (rd_dat)
  );

  // Pointers wrap through natural PTR-bit overflow because DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    error_d  = error_q | op.err;
    if (op.push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (op.pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({op.push, op.pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      error_q  <= error_d;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is always on the output. fifo_rd acknowledges it, and the next
  // word shows up right after the edge once rd_ptr advances.
  assign fifo_data_out  = rd_dat;
  assign fifo_valid_out = ~fifo_empty;
`else
  logic [WORD_SIZE-1:0] data_out_q, data_out_d;
  logic                 valid_q,    valid_d;

  // data_out holds the last popped word and valid pulses for one cycle per pop
  always_comb begin
    data_out_d = data_out_q;
    valid_d    = op.pop;
    if (op.pop) begin
      data_out_d = rd_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
    end
  end

  assign fifo_data_out  = data_out_q;
  assign fifo_valid_out = valid_q;
`endif

endmodule
